// File: rtl/mult8_nibble_seq.sv
// 8x8 unsigned multiplier sequencing four nibble products through one
// external 4x4 core, with optional golden compare and error counter.
module mult8_nibble_seq #(
  parameter bit CHECK_EN = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      P,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE, LL, LH, HL, HH, DONE
  } state_t;

  state_t           state, state_d;
  logic [7:0]       a_r, b_r;
  logic [15:0]      acc, acc_next, term, golden;
  logic             acc_en, mm_q, mm_next;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    term      = 16'h0;
    acc_en    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = LL;
      end
      LL: begin
        mul_a   = a_r[3:0];
        mul_b   = b_r[3:0];
        term    = {8'h00, mul_p};
        acc_en  = 1'b1;
        state_d = LH;
      end
      LH: begin
        mul_a   = a_r[3:0];
        mul_b   = b_r[7:4];
        term    = {4'h0, mul_p, 4'h0};
        acc_en  = 1'b1;
        state_d = HL;
      end
      HL: begin
        mul_a   = a_r[7:4];
        mul_b   = b_r[3:0];
        term    = {4'h0, mul_p, 4'h0};
        acc_en  = 1'b1;
        state_d = HH;
      end
      HH: begin
        mul_a   = a_r[7:4];
        mul_b   = b_r[7:4];
        term    = {mul_p, 8'h00};
        acc_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Faulty-core overflow simply wraps; only the compare flags it.
  assign acc_next = acc + term;
  assign golden   = {8'h00, a_r} * {8'h00, b_r};
  assign mm_next  = CHECK_EN && (acc_next != golden);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= 8'h00;
      b_r   <= 8'h00;
      acc   <= 16'h0;
      mm_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && in_valid) begin
        a_r <= A;
        b_r <= B;
        acc <= 16'h0;
      end else if (acc_en) begin
        acc <= acc_next;
      end
      if (state == HH) begin
        mm_q <= mm_next;
        if (mm_next && cnt_q != {CNT_W{1'b1}})
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign P        = acc;
  assign mismatch = CHECK_EN ? mm_q : 1'b0;
  assign err_cnt  = CHECK_EN ? cnt_q : '0;

endmodule

// File: tb/tb_mult8_nibble_seq.sv
// Directed bench: ideal and faulty 4x4 core models around two instances,
// one with the golden compare enabled and one with it disabled.
module tb_mult8_nibble_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] A = 8'h00, B = 8'h00;

  logic        in_ready, out_valid, mismatch;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic [15:0] P;
  logic [7:0]  err_cnt;

  logic        in_ready2, out_valid2, mismatch2;
  logic [3:0]  mul_a2, mul_b2;
  logic [7:0]  mul_p2;
  logic [15:0] P2;
  logic [7:0]  err_cnt2;

  logic       fault_en = 1'b0;
  logic [7:0] cur_a = 8'h00, cur_b = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    mul_p  = {4'h0, mul_a} * {4'h0, mul_b};
    mul_p2 = {4'h0, mul_a2} * {4'h0, mul_b2};
    if (fault_en && mul_a == cur_a[3:0] && mul_b == cur_b[7:4])
      mul_p = mul_p + 8'd1;
    if (fault_en && mul_a2 == cur_a[3:0] && mul_b2 == cur_b[7:4])
      mul_p2 = mul_p2 + 8'd1;
  end

  mult8_nibble_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .P(P),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  mult8_nibble_seq #(.CHECK_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .A(A), .B(B), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .out_valid(out_valid2), .out_ready(out_ready), .P(P2),
    .mismatch(mismatch2), .err_cnt(err_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, wait for out_valid, sample, advance one edge.
  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output logic mm,
                     output int lat);
    A = a; B = b; cur_a = a; cur_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    p  = P;
    mm = mismatch;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 16'h0 ||
        mismatch !== 1'b0 || err_cnt !== 8'h0 ||
        mul_a !== 4'h0 || mul_b !== 4'h0) begin
      fails++;
      $display("FAIL reset: rdy=%b ov=%b P=%h mm=%b cnt=%0d ma=%h mb=%h",
               in_ready, out_valid, P, mismatch, err_cnt, mul_a, mul_b);
    end
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b ov=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [15:0] p; logic mm; int lat;
    out_ready = 1'b1;
    txn(8'h12, 8'h34, p, mm, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL basic_latency: edges=%0d want 4", lat);
    end
    tests++;
    if (p !== 16'h03A8 || mm !== 1'b0 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL basic: P=%h mm=%b cnt=%0d want 03a8 0 0",
               p, mm, err_cnt);
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_idle: ov=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int c, t1, t2;
    logic [15:0] p1, p2;
    t1 = -1; t2 = -1; p1 = 16'h0; p2 = 16'h0;
    A = 8'hFF; B = 8'hFF;
    in_valid = 1'b1;
    step();
    A = 8'h00; B = 8'hA5;
    for (c = 1; c <= 30 && t2 < 0; c++) begin
      step();
      if (out_valid && t1 < 0) begin
        t1 = c; p1 = P;
      end else if (out_valid && t1 >= 0) begin
        t2 = c; p2 = P; in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (p1 !== 16'hFE01) begin
      fails++;
      $display("FAIL b2b_first: P=%h want fe01", p1);
    end
    tests++;
    if (p2 !== 16'h0000 || t2 < 0) begin
      fails++;
      $display("FAIL b2b_second: P=%h seen=%0d want 0000", p2, t2);
    end
    tests++;
    if (t2 - t1 !== 6) begin
      fails++;
      $display("FAIL b2b_spacing: %0d cycles want 6", t2 - t1);
    end
    step();
  endtask

  task automatic test_fault();
    logic [15:0] p; logic mm; int lat;
    fault_en = 1'b1;
    txn(8'h21, 8'h43, p, mm, lat);
    tests++;
    if (p !== 16'h08B3 || mm !== 1'b1 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL fault: P=%h mm=%b cnt=%0d want 08b3 1 1",
               p, mm, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p; logic mm; int lat;
    out_ready = 1'b0;
    txn(8'h21, 8'h43, p, mm, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      A = 8'h55; B = 8'h66;
      step();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || P !== 16'h08B3 ||
          mismatch !== 1'b1) begin
        fails++;
        $display("FAIL hold[%0d]: ov=%b rdy=%b P=%h mm=%b", i,
                 out_valid, in_ready, P, mismatch);
      end
    end
    tests++;
    if (err_cnt !== 8'd2) begin
      fails++;
      $display("FAIL hold_cnt: cnt=%0d want 2", err_cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || P !== 16'h08B3) begin
      fails++;
      $display("FAIL release: ov=%b rdy=%b P=%h want 0 1 08b3",
               out_valid, in_ready, P);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; logic mm; int lat;
    logic seen;
    txn(8'h21, 8'h43, p, mm, lat);
    tests++;
    if (err_cnt !== 8'd3) begin
      fails++;
      $display("FAIL pre_rst_cnt: cnt=%0d want 3", err_cnt);
    end
    fault_en = 1'b0;
    A = 8'h77; B = 8'h11; cur_a = 8'h77; cur_b = 8'h11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 16'h0 ||
        mismatch !== 1'b0 || err_cnt !== 8'h0 ||
        mul_a !== 4'h0 || mul_b !== 4'h0) begin
      fails++;
      $display("FAIL async_rst: rdy=%b ov=%b P=%h mm=%b cnt=%0d ma=%h mb=%h",
               in_ready, out_valid, P, mismatch, err_cnt, mul_a, mul_b);
    end
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_result: out_valid seen=%b want 0", seen);
    end
    txn(8'h03, 8'h05, p, mm, lat);
    tests++;
    if (p !== 16'h000F || mm !== 1'b0 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL post_rst: P=%h mm=%b cnt=%0d want 000f 0 0",
               p, mm, err_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] p; logic mm; int lat;
    int bad, bad2;
    bad = 0; bad2 = 0;
    fault_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      txn(8'h21, 8'h43, p, mm, lat);
      if (p !== 16'h08B3 || mm !== 1'b1) bad++;
      if (P2 !== 16'h08B3 || mismatch2 !== 1'b0 || err_cnt2 !== 8'd0)
        bad2++;
      if (i == 254) begin
        tests++;
        if (err_cnt !== 8'd255) begin
          fails++;
          $display("FAIL cnt_255: cnt=%0d want 255", err_cnt);
        end
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL sat_results: %0d bad results want 0", bad);
    end
    tests++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL saturate: cnt=%0d want 255", err_cnt);
    end
    tests++;
    if (bad2 !== 0) begin
      fails++;
      $display("FAIL nocheck_loop: %0d bad results want 0", bad2);
    end
  endtask

  task automatic test_check_dis();
    logic [15:0] p; logic mm; int lat;
    fault_en = 1'b1;
    out_ready = 1'b0;
    txn(8'h21, 8'h43, p, mm, lat);
    tests++;
    if (out_valid2 !== 1'b1 || P2 !== 16'h08B3 || mismatch2 !== 1'b0 ||
        err_cnt2 !== 8'd0) begin
      fails++;
      $display("FAIL nocheck: ov=%b P=%h mm=%b cnt=%0d want 1 08b3 0 0",
               out_valid2, P2, mismatch2, err_cnt2);
    end
    out_ready = 1'b1;
    step();
    fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_check_dis();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
